// File: rtl/rf_wr_sched_if.sv
// Writeback request, decode reservation/hazard, and rf write-port signals
// shared between the register-file write scheduler and its neighbours.
interface rf_wr_sched_if #(
    parameter int DW   = 16,
    parameter int SELW = 3
);
    logic            a_vld;
    logic [SELW-1:0] a_sel;
    logic [DW-1:0]   a_data;
    logic            a_rdy;
    logic            b_vld;
    logic [SELW-1:0] b_sel;
    logic [DW-1:0]   b_data;
    logic            b_rdy;
    logic            res_vld;
    logic [SELW-1:0] res_sel;
    logic [SELW-1:0] read1regsel;
    logic [SELW-1:0] read2regsel;
    logic            busy1;
    logic            busy2;
    logic            write;
    logic [SELW-1:0] writeregsel;
    logic [DW-1:0]   writedata;
    logic            err;

    modport master (
        output a_vld, a_sel, a_data, b_vld, b_sel, b_data,
               res_vld, res_sel, read1regsel, read2regsel,
        input  a_rdy, b_rdy, busy1, busy2, write, writeregsel, writedata, err
    );

    modport slave (
        input  a_vld, a_sel, a_data, b_vld, b_sel, b_data,
               res_vld, res_sel, read1regsel, read2regsel,
        output a_rdy, b_rdy, busy1, busy2, write, writeregsel, writedata, err
    );
endinterface

// File: rtl/rf_wr_sched.sv
// Shares the rf write port between ALU (A) and load (B) writeback with
// round-robin arbitration, and keeps a pending-write scoreboard for RAW stalls.
module rf_wr_sched #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic         clk,
    input  logic         rst,
    rf_wr_sched_if.slave bus
);
    localparam int SELW = $clog2(NREG);

    function automatic logic [NREG-1:0] onehot(input logic [SELW-1:0] sel);
        logic [NREG-1:0] one_s;
        one_s = {{(NREG-1){1'b0}}, 1'b1};
        return one_s << sel;
    endfunction

    logic            grant_a_s;
    logic            grant_b_s;
    logic [NREG-1:0] pend_clr_s;
    logic [NREG-1:0] pend_set_s;
    logic [NREG-1:0] pend_nxt_s;
    logic            err_nxt_s;

    logic            prio_r;
    logic            write_r;
    logic [SELW-1:0] sel_r;
    logic [DW-1:0]   data_r;
    logic [NREG-1:0] pend_r;
    logic            err_r;

    // Arbitration: prio_r names the requester that wins a conflict.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (bus.a_vld && bus.b_vld) begin
            grant_a_s = ~prio_r;
            grant_b_s = prio_r;
        end else begin
            grant_a_s = bus.a_vld;
            grant_b_s = bus.b_vld;
        end
    end

    // Scoreboard next state and protocol-error detection; a set overrides a same-edge clear.
    always_comb begin
        pend_clr_s = {NREG{1'b0}};
        pend_set_s = {NREG{1'b0}};
        if (write_r) begin
            pend_clr_s = onehot(sel_r);
        end else begin
            pend_clr_s = {NREG{1'b0}};
        end
        if (bus.res_vld) begin
            pend_set_s = onehot(bus.res_sel);
        end else begin
            pend_set_s = {NREG{1'b0}};
        end
        pend_nxt_s = (pend_r & ~pend_clr_s) | pend_set_s;
        err_nxt_s  = err_r
                   | (bus.res_vld & pend_r[bus.res_sel] & ~pend_clr_s[bus.res_sel])
                   | (write_r & ~pend_r[sel_r]);
    end

    // Write stage, arbitration priority, scoreboard and sticky error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r  <= 1'b0;
            write_r <= 1'b0;
            sel_r   <= {SELW{1'b0}};
            data_r  <= {DW{1'b0}};
            pend_r  <= {NREG{1'b0}};
            err_r   <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            err_r  <= err_nxt_s;
            if (grant_a_s) begin
                write_r <= 1'b1;
                sel_r   <= bus.a_sel;
                data_r  <= bus.a_data;
                prio_r  <= 1'b1;
            end else if (grant_b_s) begin
                write_r <= 1'b1;
                sel_r   <= bus.b_sel;
                data_r  <= bus.b_data;
                prio_r  <= 1'b0;
            end else begin
                write_r <= 1'b0;
            end
        end
    end

    assign bus.a_rdy       = grant_a_s;
    assign bus.b_rdy       = grant_b_s;
    assign bus.busy1       = pend_r[bus.read1regsel];
    assign bus.busy2       = pend_r[bus.read2regsel];
    assign bus.write       = write_r;
    assign bus.writeregsel = sel_r;
    assign bus.writedata   = data_r;
    assign bus.err         = err_r;
endmodule
